// File: rtl/reg_trigseq_pkg.sv
// Shared definitions for the register-programmable trigger sequencer:
// bus address default, FSM state encoding and config byte offsets.
package reg_trigseq_pkg;

  localparam logic [5:0]  SEQ_ADDR_DEF = 6'd52;
  localparam int unsigned DLY_W_DEF    = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  localparam logic [2:0] BYTE_CTRL  = 3'd0;
  localparam logic [2:0] BYTE_DLY0  = 3'd1;
  localparam logic [2:0] BYTE_DLY1  = 3'd2;
  localparam logic [2:0] BYTE_DLY2  = 3'd3;
  localparam logic [2:0] BYTE_WIDTH = 3'd4;
  localparam logic [2:0] BYTE_COUNT = 3'd5;
  localparam logic [2:0] BYTE_GAP0  = 3'd6;
  localparam logic [2:0] BYTE_GAP1  = 3'd7;

  // Length-minus-one for a phase whose programmed value 0 means 1.
  function automatic logic [15:0] len_m1(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

endpackage

// File: rtl/trigseq_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector;
// edge_o pulses for one cycle, three edges after an input rise.
module trigseq_sync_edge (
  input  logic clk,
  input  logic reset_i,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q, s2_q, prev_q, edge_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      edge_q <= s2_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/reg_trigseq.sv
// Trigger sequencer: after arm and a trigger edge, emits count+1 pulses of
// programmable width with programmable start delay and inter-pulse gap.
module reg_trigseq
  import reg_trigseq_pkg::*;
#(
  parameter logic [5:0]  SEQ_ADDR = SEQ_ADDR_DEF,
  parameter int unsigned DLY_W    = DLY_W_DEF
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  input  logic        trig_i,
  output logic        pulse_o,
  output logic        armed_o,
  output logic        busy_o,
  output logic        done_o
);

  logic        wr_sel, rd_sel, arm_s, abort_s, trig_edge;
  logic [23:0] cfg_delay_q;
  logic [7:0]  cfg_width_q, cfg_count_q;
  logic [15:0] cfg_gap_q;
  logic [23:0] w_delay_q;
  logic [7:0]  w_width_q;
  logic [15:0] w_gap_q;
  logic        load_work;

  seq_state_e       state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic             pulse_q;
  logic [7:0]       rdata;

  trigseq_sync_edge u_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .async_i (trig_i),
    .edge_o  (trig_edge)
  );

  assign wr_sel  = reg_write && reg_addrvalid && (reg_address == SEQ_ADDR)
                   && (reg_bytecnt < 16'd8);
  assign rd_sel  = reg_read && reg_addrvalid && (reg_address == SEQ_ADDR);
  assign arm_s   = wr_sel && (reg_bytecnt[2:0] == BYTE_CTRL) && reg_datai[0];
  assign abort_s = wr_sel && (reg_bytecnt[2:0] == BYTE_CTRL) && reg_datai[1];

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cfg_delay_q <= '0;
      cfg_width_q <= 8'd1;
      cfg_count_q <= '0;
      cfg_gap_q   <= 16'd1;
    end else if (wr_sel) begin
      case (reg_bytecnt[2:0])
        BYTE_DLY0:  cfg_delay_q[7:0]   <= reg_datai;
        BYTE_DLY1:  cfg_delay_q[15:8]  <= reg_datai;
        BYTE_DLY2:  cfg_delay_q[23:16] <= reg_datai;
        BYTE_WIDTH: cfg_width_q        <= reg_datai;
        BYTE_COUNT: cfg_count_q        <= reg_datai;
        BYTE_GAP0:  cfg_gap_q[7:0]     <= reg_datai;
        BYTE_GAP1:  cfg_gap_q[15:8]    <= reg_datai;
        default: ;
      endcase
    end
  end

  // Working copy taken at arm so later config writes only affect the next arm.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      w_delay_q <= '0;
      w_width_q <= 8'd1;
      w_gap_q   <= 16'd1;
    end else if (load_work) begin
      w_delay_q <= cfg_delay_q;
      w_width_q <= cfg_width_q;
      w_gap_q   <= cfg_gap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= (state_d == ST_PULSE);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    load_work = 1'b0;
    if (abort_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_s) begin
            state_d   = ST_ARMED;
            load_work = 1'b1;
            pcnt_d    = cfg_count_q;
          end
        end
        ST_ARMED: begin
          if (trig_edge) begin
            if (w_delay_q != 24'd0) begin
              state_d = ST_DELAY;
              cnt_d   = DLY_W'(w_delay_q - 24'd1);
            end else begin
              state_d = ST_PULSE;
              cnt_d   = DLY_W'(len_m1({8'd0, w_width_q}));
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == '0) begin
            state_d = ST_PULSE;
            cnt_d   = DLY_W'(len_m1({8'd0, w_width_q}));
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            if (pcnt_q == 8'd0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_GAP;
              pcnt_d  = pcnt_q - 8'd1;
              cnt_d   = DLY_W'(len_m1(w_gap_q));
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_PULSE;
            cnt_d   = DLY_W'(len_m1({8'd0, w_width_q}));
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pulse_o = pulse_q;
  assign armed_o = (state_q == ST_ARMED);
  assign busy_o  = (state_q == ST_DELAY) || (state_q == ST_PULSE) || (state_q == ST_GAP);
  assign done_o  = (state_q == ST_DONE);

  always_comb begin
    rdata = '0;
    if (rd_sel) begin
      case (reg_bytecnt[2:0])
        BYTE_CTRL:  rdata = {5'b0, done_o, busy_o, armed_o};
        BYTE_DLY0:  rdata = cfg_delay_q[7:0];
        BYTE_DLY1:  rdata = cfg_delay_q[15:8];
        BYTE_DLY2:  rdata = cfg_delay_q[23:16];
        BYTE_WIDTH: rdata = cfg_width_q;
        BYTE_COUNT: rdata = cfg_count_q;
        BYTE_GAP0:  rdata = cfg_gap_q[7:0];
        BYTE_GAP1:  rdata = cfg_gap_q[15:8];
        default:    rdata = '0;
      endcase
    end
  end

  assign reg_datao  = rdata;
  assign reg_hyplen = (reg_hypaddress == SEQ_ADDR) ? 16'd8 : 16'd0;

endmodule

// File: tb/tb_reg_trigseq.sv
// Directed bench for reg_trigseq: register access, pulse trains, abort,
// re-arm config isolation, 256-pulse boundary and mid-sequence reset.
module tb_reg_trigseq;

  localparam logic [5:0] SA = 6'd52;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [5:0]  reg_address = '0;
  logic [15:0] reg_bytecnt = '0;
  logic [7:0]  reg_datai = '0;
  logic [7:0]  reg_datao;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        reg_addrvalid = 1'b0;
  logic [5:0]  reg_hypaddress = '0;
  logic [15:0] reg_hyplen;
  logic        trig_i = 1'b0;
  logic        pulse_o, armed_o, busy_o, done_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  reg_trigseq #(.SEQ_ADDR(SA), .DLY_W(24)) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .trig_i         (trig_i),
    .pulse_o        (pulse_o),
    .armed_o        (armed_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] d);
    reg_address = a; reg_bytecnt = bc; reg_datai = d;
    reg_write = 1'b1; reg_addrvalid = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] bc, output logic [7:0] d);
    reg_address = a; reg_bytecnt = bc;
    reg_read = 1'b1; reg_addrvalid = 1'b1;
    #1 d = reg_datao;
    reg_read = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic set_cfg(input logic [23:0] dly, input logic [7:0] w,
                         input logic [7:0] c, input logic [15:0] g);
    wr(SA, 16'd1, dly[7:0]);
    wr(SA, 16'd2, dly[15:8]);
    wr(SA, 16'd3, dly[23:16]);
    wr(SA, 16'd4, w);
    wr(SA, 16'd5, c);
    wr(SA, 16'd6, g[7:0]);
    wr(SA, 16'd7, g[15:8]);
  endtask

  task automatic trig_low();
    trig_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  d;
    logic [31:0] pv, bv;
    logic        any_pulse, prev;
    int unsigned rises;

    // Reset
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, pulse_o, armed_o, busy_o, done_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    rd(SA, 16'd0, d);       check("reset_status", {24'd0, d}, 32'h00);
    rd(SA, 16'd4, d);       check("reset_width",  {24'd0, d}, 32'h01);
    rd(SA, 16'd6, d);       check("reset_gap0",   {24'd0, d}, 32'h01);

    // Register bus decode
    reg_hypaddress = SA;    #1 check("hyplen_sel", {16'd0, reg_hyplen}, 32'd8);
    reg_hypaddress = 6'd3;  #1 check("hyplen_other", {16'd0, reg_hyplen}, 32'd0);
    rd(6'd51, 16'd4, d);    check("read_other_addr", {24'd0, d}, 32'h00);
    @(negedge clk);

    // Simultaneous arm+abort: abort wins, stays idle
    wr(SA, 16'd0, 8'h03);
    rd(SA, 16'd0, d);       check("arm_abort", {24'd0, d}, 32'h00);
    @(negedge clk);

    // Single pulse: delay=10, width=3
    set_cfg(24'd10, 8'd3, 8'd0, 16'd1);
    wr(SA, 16'd0, 8'h01);
    check("armed_after_arm", {31'd0, armed_o}, 32'd1);
    trig_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); pv[i] = pulse_o;
    end
    check("t1_pulse_pattern", pv, 32'h0000_E000);
    rd(SA, 16'd0, d);       check("t1_status_done", {24'd0, d}, 32'h04);
    @(negedge clk);
    trig_low();

    // Three pulses: delay=0, width=2, count=2, gap=4
    set_cfg(24'd0, 8'd2, 8'd2, 16'd4);
    wr(SA, 16'd0, 8'h01);
    trig_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); pv[i] = pulse_o; bv[i] = busy_o;
    end
    check("t2_pulse_pattern", pv, 32'h0001_8618);
    check("t2_busy_pattern",  bv, 32'h0001_FFF8);
    check("t2_done", {31'd0, done_o}, 32'd1);
    trig_low();

    // Zero width/gap treated as 1: pattern 1,0,1
    set_cfg(24'd0, 8'd0, 8'd1, 16'd0);
    wr(SA, 16'd0, 8'h01);
    trig_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); pv[i] = pulse_o;
    end
    check("t3_pulse_pattern", pv, 32'h0000_0028);
    trig_low();

    // Abort during a long delay
    set_cfg(24'd1000, 8'd1, 8'd0, 16'd1);
    wr(SA, 16'd0, 8'h01);
    trig_i = 1'b1;
    any_pulse = 1'b0;
    repeat (4) begin
      @(negedge clk); any_pulse |= pulse_o;
    end
    check("t4_busy_in_delay", {31'd0, busy_o}, 32'd1);
    wr(SA, 16'd0, 8'h02);
    rd(SA, 16'd0, d);       check("t4_status_after_abort", {24'd0, d}, 32'h00);
    trig_i = 1'b0;
    repeat (5) begin
      @(negedge clk); any_pulse |= pulse_o;
    end
    trig_i = 1'b1;
    repeat (40) begin
      @(negedge clk); any_pulse |= pulse_o;
    end
    check("t4_no_pulse", {31'd0, any_pulse}, 32'd0);
    rd(SA, 16'd0, d);       check("t4_second_trig_ignored", {24'd0, d}, 32'h00);
    @(negedge clk);
    trig_low();

    // Config written after arm only applies to the next arm
    set_cfg(24'd20, 8'd1, 8'd0, 16'd1);
    wr(SA, 16'd0, 8'h01);
    wr(SA, 16'd1, 8'd5);
    trig_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); pv[i] = pulse_o;
    end
    check("t5_first_uses_20", pv, 32'h0080_0000);
    trig_low();
    wr(SA, 16'd0, 8'h01);
    trig_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); pv[i] = pulse_o;
    end
    check("t5_rearm_uses_5", pv, 32'h0000_0100);
    trig_low();

    // Writes beyond the 8-byte block are ignored
    wr(SA, 16'd9, 8'h55);
    rd(SA, 16'd1, d);       check("bytecnt9_ignored", {24'd0, d}, 32'h05);
    @(negedge clk);
    wr(SA, 16'd8, 8'h01);
    check("bytecnt8_no_arm", {31'd0, armed_o}, 32'd0);

    // count=255 gives 256 pulses
    set_cfg(24'd0, 8'd1, 8'd255, 16'd1);
    wr(SA, 16'd0, 8'h01);
    trig_i = 1'b1;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (pulse_o && !prev) rises++;
      prev = pulse_o;
    end
    check("t6_pulse_count_256", rises, 32'd256);
    check("t6_done", {31'd0, done_o}, 32'd1);
    trig_low();

    // Reset mid-pulse drops pulse next cycle and restores config
    set_cfg(24'd0, 8'd10, 8'd0, 16'd1);
    wr(SA, 16'd0, 8'h01);
    trig_i = 1'b1;
    repeat (6) @(negedge clk);
    check("t7_pulse_high", {31'd0, pulse_o}, 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    check("t7_pulse_dropped", {28'd0, pulse_o, armed_o, busy_o, done_o}, 32'd0);
    reset_i = 1'b0;
    trig_i = 1'b0;
    rd(SA, 16'd4, d);       check("t7_width_default", {24'd0, d}, 32'h01);
    rd(SA, 16'd1, d);       check("t7_delay_zero", {24'd0, d}, 32'h00);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
